// File: rtl/keypad_matrix_emu.sv
// Switch-side emulator for a 1x4 scanned keypad: pulls the addressed column low
// while an emulated key is pressed, with LFSR-driven contact bounce on press and release.
module keypad_matrix_emu #(
  parameter int unsigned TICK_CYC     = 50_000,
  parameter int unsigned BOUNCE_TICKS = 5,
  parameter int unsigned BOUNCE_STEP  = 2_500,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_key,
  input  logic [15:0] req_hold,
  input  logic        abort,
  input  logic        key_row,
  output logic [3:0]  key_col,
  output logic        busy,
  output logic        done
);
  localparam int unsigned CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned SW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_CYC - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(BOUNCE_STEP - 1);
  localparam logic [16:0]   BNC_LAST  = 17'(BOUNCE_TICKS) - 17'd1;

  typedef enum logic [2:0] {S_IDLE, S_BON, S_HOLD, S_BOFF, S_FIN} state_e;

  state_e        state_q, state_d;
  logic          contact_q, contact_d;
  logic [1:0]    key_q, key_d;
  logic [16:0]   hold_q, hold_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [16:0]   tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          clr;

  logic        tick_end, bnc_end, hold_end, draw;
  logic [15:0] lfsr_nx;

  assign tick_end = (cyc_q == CYC_LAST);
  assign bnc_end  = tick_end && (tick_q == BNC_LAST);
  assign hold_end = tick_end && (tick_q == hold_q - 17'd1);
  assign draw     = (step_q == '0);
  assign lfsr_nx  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    key_d     = key_q;
    hold_d    = hold_q;
    lfsr_d    = lfsr_q;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_valid && !abort) begin
        key_d  = req_key;
        hold_d = (req_hold == '0) ? 17'd1 : {1'b0, req_hold};
        clr    = 1'b1;
        if (BOUNCE_TICKS == 0) begin
          state_d   = S_HOLD;
          contact_d = 1'b1;
        end else begin
          state_d = S_BON;
        end
      end
      S_BON: begin
        if (bnc_end) begin
          state_d   = S_HOLD;
          contact_d = 1'b1;
          clr       = 1'b1;
        end else if (draw) begin
          contact_d = lfsr_q[0];
          lfsr_d    = lfsr_nx;
        end
      end
      S_HOLD: if (hold_end) begin
        clr = 1'b1;
        // Without a bounce window the release is clean and goes straight to FIN.
        if (BOUNCE_TICKS == 0) begin
          state_d   = S_FIN;
          contact_d = 1'b0;
        end else begin
          state_d = S_BOFF;
        end
      end
      S_BOFF: begin
        if (bnc_end) begin
          state_d   = S_FIN;
          contact_d = 1'b0;
          clr       = 1'b1;
        end else if (draw) begin
          contact_d = lfsr_q[0];
          lfsr_d    = lfsr_nx;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        clr     = 1'b1;
      end
      default: begin
        state_d   = S_IDLE;
        contact_d = 1'b0;
        clr       = 1'b1;
      end
    endcase
    // Abort overrides everything, including any bounce draw due this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      contact_d = 1'b0;
      lfsr_d    = lfsr_q;
      clr       = 1'b1;
    end
    if (clr || state_q == S_IDLE) begin
      cyc_d  = '0;
      tick_d = '0;
      step_d = '0;
    end else begin
      cyc_d  = tick_end ? '0 : cyc_q + CW'(1);
      tick_d = tick_end ? tick_q + 17'd1 : tick_q;
      step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      contact_q <= 1'b0;
      key_q     <= '0;
      hold_q    <= '0;
      cyc_q     <= '0;
      tick_q    <= '0;
      step_q    <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      cyc_q     <= cyc_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  // Switch-matrix behaviour: the column follows the row drive combinationally.
  for (genvar i = 0; i < 4; i++) begin : g_col
    assign key_col[i] = ~(contact_q && (key_q == 2'(i)) && !key_row);
  end

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Randomized bench for keypad_matrix_emu: a timeline model of the press/bounce/hold/release
// sequence predicts key_col, done, busy and req_ready for every cycle.
module tb_keypad_matrix_emu;
  localparam int TC = 10, BT = 2, BS = 4;
  localparam int unsigned SEED = 32'h0000ACE1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, abort = 1'b0, key_row = 1'b0;
  logic [1:0]  req_key = '0;
  logic [15:0] req_hold = '0;
  logic        req_ready, busy, done;
  logic [3:0]  key_col;

  logic        nb_valid = 1'b0, nb_abort = 1'b0, nb_row = 1'b0;
  logic [1:0]  nb_key = '0;
  logic [15:0] nb_hold = '0;
  logic        nb_ready, nb_busy, nb_done;
  logic [3:0]  nb_col;

  keypad_matrix_emu #(.TICK_CYC(TC), .BOUNCE_TICKS(BT), .BOUNCE_STEP(BS), .LFSR_SEED(16'hACE1)) u_dut (
    .clk_50M(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_hold(req_hold), .abort(abort), .key_row(key_row),
    .key_col(key_col), .busy(busy), .done(done));

  keypad_matrix_emu #(.TICK_CYC(TC), .BOUNCE_TICKS(0), .BOUNCE_STEP(BS), .LFSR_SEED(16'hACE1)) u_nb (
    .clk_50M(clk), .rst_n(rst_n), .req_valid(nb_valid), .req_ready(nb_ready),
    .req_key(nb_key), .req_hold(nb_hold), .abort(nb_abort), .key_row(nb_row),
    .key_col(nb_col), .busy(nb_busy), .done(nb_done));

  int n_chk = 0, n_pass = 0;
  int unsigned lfsr_m = SEED;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Returns bit 0 of the current LFSR value, then advances (taps 16,14,13,11).
  function automatic bit draw_m();
    bit b;
    int unsigned fb;
    b = bit'(lfsr_m & 1);
    fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
    lfsr_m = ((lfsr_m << 1) | fb) & 32'hFFFF;
    return b;
  endfunction

  // Starts with the bench at an idle cycle, ends at the next idle cycle (checked).
  // row_mode: 0 row low, 1 random row, 2 row high for 5 cycles in HOLD.
  task automatic run_tx(input int key, input int hold, input int row_mode,
                        input int abort_at, input int rst_at, input int dup_at);
    int B, H, tot, k;
    bit con, row;
    logic [3:0] one, exp_col;
    B = BT * TC;
    H = ((hold == 0) ? 1 : hold) * TC;
    tot = 2 * B + H + 1;
    con = 1'b0;
    one = 4'b0001;
    req_valid = 1'b1; req_key = 2'(key); req_hold = 16'(hold);
    @(negedge clk);
    for (int c = 1; c <= tot; c++) begin
      case (row_mode)
        1: row = ($urandom_range(0, 3) == 0);
        2: row = (c >= B + 5 && c <= B + 9);
        default: row = 1'b0;
      endcase
      key_row = row;
      req_valid = (c == dup_at);
      req_key = (c == dup_at) ? 2'd1 : 2'(key);
      abort = (c == abort_at);
      if (c == rst_at) rst_n = 1'b0;
      #1;
      if (c == rst_at) begin
        chk("rst_async_col", key_col, 4'hF);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_ready", req_ready, 1'b1);
        lfsr_m = SEED;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      exp_col = (con && !row) ? ~(one << key) : 4'hF;
      chk("col", key_col, exp_col);
      chk("done", done, c == tot);
      chk("busy", busy, 1'b1);
      chk("ready", req_ready, 1'b0);
      if (c == abort_at) begin
        @(negedge clk);
        break;
      end
      if (c < B) begin
        if ((c - 1) % BS == 0) con = draw_m();
      end else if (c <= B + H) begin
        con = 1'b1;
      end else if (c <= 2 * B + H) begin
        k = c - B - H;
        if (k == B) con = 1'b0;
        else if ((k - 1) % BS == 0) con = draw_m();
      end
      @(negedge clk);
    end
    req_valid = 1'b0; abort = 1'b0; key_row = 1'b0;
    #1;
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_col", key_col, 4'hF);
  endtask

  initial begin
    int kk, hh, rm, ab, nd;
    key_row = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_col", key_col, 4'hF);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_nb_col", nb_col, 4'hF);
    chk("reset_nb_ready", nb_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    run_tx(2, 3, 0, 0, 0, 0);       // basic press of key 2
    run_tx(2, 3, 2, 0, 0, 0);       // row released mid-HOLD
    run_tx(2, 3, 0, 0, 0, 3);       // second request during B_ON
    run_tx(1, 2, 0, 35, 0, 0);      // abort in HOLD
    run_tx(3, 1, 1, 0, 0, 0);       // accepted right after abort

    // abort in IDLE blocks a same-cycle accept
    req_valid = 1'b1; abort = 1'b1; req_key = 2'd0; req_hold = 16'd1;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    #1;
    chk("idle_abort_ready", req_ready, 1'b1);
    chk("idle_abort_busy", busy, 1'b0);

    run_tx(0, 2, 0, 0, 30, 0);      // reset mid-HOLD
    run_tx(0, 0, 0, 0, 0, 0);       // hold=0 behaves as hold=1

    for (int i = 0; i < 8; i++) begin
      kk = $urandom_range(0, 3);
      hh = $urandom_range(0, 3);
      rm = $urandom_range(0, 1);
      ab = ($urandom_range(0, 3) == 0) ? BT * TC + $urandom_range(1, ((hh == 0) ? 1 : hh) * TC) : 0;
      run_tx(kk, hh, rm, ab, 0, 0);
    end

    // no-bounce build: clean 10-cycle press on column 0
    nb_valid = 1'b1; nb_key = 2'd0; nb_hold = 16'd0;
    @(negedge clk);
    nb_valid = 1'b0;
    #1;
    nd = 0;
    for (int c = 1; c <= 14; c++) begin
      chk("nb_col", nb_col, (c <= TC) ? 4'b1110 : 4'hF);
      nd += int'(nb_done);
      @(negedge clk);
      #1;
    end
    chk("nb_done_count", nd, 1);
    chk("nb_ready_after", nb_ready, 1'b1);
    chk("nb_busy_after", nb_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
